ring_switch_rr: RTL and testbench

- Parametrised ring router node for the mini-AIE CGRA; one instance per PE, chained into a unidirectional ring.
- Each node ejects ring flits addressed to its own RANK and forwards all others.
- The local PE injects flits onto the ring, or loops them back locally when addressed to itself.
- Replaces change-detect signalling with valid/ready handshakes, per-input FIFOs and round-robin output arbitration.

---
 rtl/ring_switch_rr_if.sv | 17 +
 rtl/ring_switch_rr.sv | 273 +++++++++++++++++++++++++++
 tb/tb_ring_switch_rr.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ring_switch_rr_if.sv
`timescale 1ns/1ps
// Single-direction flit stream between a producer and a consumer.
//
// Handshake: a flit moves when valid && ready at the rising clk edge. Once
// the master raises valid it holds valid and data stable until that edge.
// ready may change freely, and the master never waits for ready before it
// raises valid.
interface ring_switch_rr_if #(
  parameter int DATA_W = 8
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/ring_switch_rr.sv
`timescale 1ns/1ps
// Ring router node: one instance per PE, chained into a unidirectional ring.
// Ring flits addressed to RANK are ejected to the PE, and all other ring
// flits are forwarded. PE flits addressed to RANK loop back to the PE, and
// all others are injected onto the ring. Each input is buffered in a small
// FIFO. Each output is one register with its own two-way round-robin arbiter.

// Circular-buffer FIFO. in_ready depends only on the registered count.
module ring_switch_rr_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  input  logic              pop,
  output logic              head_valid,
  output logic [DATA_W-1:0] head_data
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              push;

  // push_ready low keeps a full FIFO from being written.
  always_comb begin
    push_ready = (count_q < FULL_CNT);
    push       = push_valid && push_ready;
    head_valid = (count_q != '0);
    head_data  = mem[rd_ptr_q];
  end

  // Storage holds no reset state; only the pointers and count say what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  // Pointers wrap at FIFO_DEPTH. A push and a pop in the same cycle leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// Two-way round-robin arbiter for one output (ring FIFO vs PE FIFO).
// prio_pe_q == 0 favours the ring input; reset lands there.
module ring_switch_rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req_ring,
  input  logic req_pe,
  input  logic load_en,
  output logic gnt_ring,
  output logic gnt_pe
);
  logic prio_pe_q;

  // A lone requester wins. On a tie the side named by the pointer wins.
  always_comb begin
    gnt_ring = 1'b0;
    gnt_pe   = 1'b0;
    if (load_en) begin
      if (req_ring && (!req_pe || !prio_pe_q)) begin
        gnt_ring = 1'b1;
      end else if (req_pe) begin
        gnt_pe = 1'b1;
      end
    end
  end

  // After any grant the pointer points at the side that was not served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_pe_q <= 1'b0;
    end else if (gnt_ring) begin
      prio_pe_q <= 1'b1;
    end else if (gnt_pe) begin
      prio_pe_q <= 1'b0;
    end
  end
endmodule

// Single-entry output register. It can reload in the same cycle it is drained.
module ring_switch_rr_out_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data
);
  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  // A load wins. Otherwise a downstream accept empties the stage. A stall holds valid and data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= load_data;
    end else if (ready) begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
endmodule

module ring_switch_rr #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 2,
  parameter int ADDR_LSB   = 4,
  parameter int RANK       = 0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ring_switch_rr_if.slave        ring_in,
  ring_switch_rr_if.master       ring_out,
  ring_switch_rr_if.slave        pe_in,
  ring_switch_rr_if.master       pe_out,
  output logic                   ring_fifo_full
);
  localparam logic [ADDR_W-1:0] MY_ADDR = ADDR_W'(RANK);

  logic              ring_in_ready_w;
  logic              pe_in_ready_w;
  logic              ring_hv;
  logic              pe_hv;
  logic [DATA_W-1:0] ring_head;
  logic [DATA_W-1:0] pe_head;
  logic              ring_pop;
  logic              pe_pop;

  logic              ring_to_pe;
  logic              ring_to_ring;
  logic              pe_to_pe;
  logic              pe_to_ring;

  logic              ro_valid;
  logic [DATA_W-1:0] ro_data;
  logic              po_valid;
  logic [DATA_W-1:0] po_data;
  logic              ro_load_en;
  logic              po_load_en;
  logic              ro_gnt_ring;
  logic              ro_gnt_pe;
  logic              po_gnt_ring;
  logic              po_gnt_pe;

  ring_switch_rr_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_ring_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (ring_in.valid),
    .push_data  (ring_in.data),
    .push_ready (ring_in_ready_w),
    .pop        (ring_pop),
    .head_valid (ring_hv),
    .head_data  (ring_head)
  );

  ring_switch_rr_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_pe_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (pe_in.valid),
    .push_data  (pe_in.data),
    .push_ready (pe_in_ready_w),
    .pop        (pe_pop),
    .head_valid (pe_hv),
    .head_data  (pe_head)
  );

  assign ring_in.ready  = ring_in_ready_w;
  assign pe_in.ready    = pe_in_ready_w;
  // Full is simply "cannot accept": both come from the same registered count.
  assign ring_fifo_full = !ring_in_ready_w;

  // Route each FIFO head by its destination field. A head requests exactly one output.
  always_comb begin
    ring_to_pe   = ring_hv && (ring_head[ADDR_LSB +: ADDR_W] == MY_ADDR);
    ring_to_ring = ring_hv && (ring_head[ADDR_LSB +: ADDR_W] != MY_ADDR);
    pe_to_pe     = pe_hv   && (pe_head[ADDR_LSB +: ADDR_W]   == MY_ADDR);
    pe_to_ring   = pe_hv   && (pe_head[ADDR_LSB +: ADDR_W]   != MY_ADDR);
  end

  // An output stage can take a new flit when it is empty or being drained this edge.
  always_comb begin
    ro_load_en = !ro_valid || ring_out.ready;
    po_load_en = !po_valid || pe_out.ready;
  end

  ring_switch_rr_arb2 u_ring_out_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_ring (ring_to_ring),
    .req_pe   (pe_to_ring),
    .load_en  (ro_load_en),
    .gnt_ring (ro_gnt_ring),
    .gnt_pe   (ro_gnt_pe)
  );

  ring_switch_rr_arb2 u_pe_out_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_ring (ring_to_pe),
    .req_pe   (pe_to_pe),
    .load_en  (po_load_en),
    .gnt_ring (po_gnt_ring),
    .gnt_pe   (po_gnt_pe)
  );

  // Each head requests one output only, so it pops at most once per cycle. A loser simply waits.
  always_comb begin
    ring_pop = ro_gnt_ring || po_gnt_ring;
    pe_pop   = ro_gnt_pe   || po_gnt_pe;
  end

  ring_switch_rr_out_reg #(.DATA_W(DATA_W)) u_ring_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ro_gnt_ring || ro_gnt_pe),
    .load_data (ro_gnt_ring ? ring_head : pe_head),
    .ready     (ring_out.ready),
    .valid     (ro_valid),
    .data      (ro_data)
  );

  ring_switch_rr_out_reg #(.DATA_W(DATA_W)) u_pe_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (po_gnt_ring || po_gnt_pe),
    .load_data (po_gnt_ring ? ring_head : pe_head),
    .ready     (pe_out.ready),
    .valid     (po_valid),
    .data      (po_data)
  );

  assign ring_out.valid = ro_valid;
  assign ring_out.data  = ro_data;
  assign pe_out.valid   = po_valid;
  assign pe_out.data    = po_data;
endmodule

// File: tb/tb_ring_switch_rr.sv
`timescale 1ns/1ps
// Bench for ring_switch_rr at RANK=1 with default widths and FIFO_DEPTH=2.
// Reference model: every accepted flit is routed by its destination into one
// of four expected queues (output x source). Each output transfer must match
// the oldest pending flit from one of its two sources. Held outputs must stay
// stable. Directed cases pin exact order and latency with literal values.
module tb_ring_switch_rr;
  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 2;
  localparam int ADDR_LSB   = 4;
  localparam int FIFO_DEPTH = 2;
  localparam logic [ADDR_W-1:0] MY_ADDR = 2'd1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ring_fifo_full;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ring_switch_rr_if #(.DATA_W(DATA_W)) ring_in  ();
  ring_switch_rr_if #(.DATA_W(DATA_W)) ring_out ();
  ring_switch_rr_if #(.DATA_W(DATA_W)) pe_in    ();
  ring_switch_rr_if #(.DATA_W(DATA_W)) pe_out   ();

  ring_switch_rr #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ADDR_LSB(ADDR_LSB),
    .RANK(1), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ring_in        (ring_in.slave),
    .ring_out       (ring_out.master),
    .pe_in          (pe_in.slave),
    .pe_out         (pe_out.master),
    .ring_fifo_full (ring_fifo_full)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] ring_src_q[$];
  logic [DATA_W-1:0] pe_src_q[$];
  logic [DATA_W-1:0] exp_ro_from_ring[$];
  logic [DATA_W-1:0] exp_ro_from_pe[$];
  logic [DATA_W-1:0] exp_po_from_ring[$];
  logic [DATA_W-1:0] exp_po_from_pe[$];
  int ring_acc_c[$];
  int pe_acc_c[$];
  int ro_d[$];
  int ro_c[$];
  int po_d[$];
  int po_c[$];

  bit       rand_gaps = 1'b0;
  int       ro_mode = 0;  // 0 always ready, 1 random, 2 stalled
  int       po_mode = 0;
  bit       ro_hold = 1'b0;
  bit       po_hold = 1'b0;
  logic [DATA_W-1:0] ro_hold_d;
  logic [DATA_W-1:0] po_hold_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1000;
  endfunction

  function automatic string head_str(input logic [DATA_W-1:0] q[$]);
    return (q.size() > 0) ? $sformatf("%02h", q[0]) : "none";
  endfunction

  task automatic clear_model();
    ring_src_q.delete(); pe_src_q.delete();
    exp_ro_from_ring.delete(); exp_ro_from_pe.delete();
    exp_po_from_ring.delete(); exp_po_from_pe.delete();
    ring_acc_c.delete(); pe_acc_c.delete();
    ro_d.delete(); ro_c.delete(); po_d.delete(); po_c.delete();
  endtask

  // Route an accepted flit into the queue of the output it must leave on.
  task automatic model_accept(input logic [DATA_W-1:0] d, input bit from_pe);
    bit local_dest;
    local_dest = (d[ADDR_LSB +: ADDR_W] == MY_ADDR);
    if (from_pe) begin
      pe_acc_c.push_back(cyc);
      if (local_dest) exp_po_from_pe.push_back(d); else exp_ro_from_pe.push_back(d);
    end else begin
      ring_acc_c.push_back(cyc);
      if (local_dest) exp_po_from_ring.push_back(d); else exp_ro_from_ring.push_back(d);
    end
  endtask

  // ---------------- driver processes ----------------
  initial begin : ring_driver
    bit acc;
    logic [DATA_W-1:0] d;
    ring_in.valid = 1'b0;
    ring_in.data  = '0;
    forever begin
      @(negedge clk);
      acc = ring_in.valid && ring_in.ready && rst_n;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        ring_in.valid = 1'b0;
        ring_in.data  = '0;
      end else begin
        if (acc && ring_src_q.size() > 0) begin
          d = ring_src_q.pop_front();
          model_accept(d, 1'b0);
          ring_in.valid = 1'b0;
        end
        if (!ring_in.valid && ring_src_q.size() > 0 && (!rand_gaps || $urandom_range(0, 3) != 0)) begin
          ring_in.valid = 1'b1;
          ring_in.data  = ring_src_q[0];
        end
      end
    end
  end

  initial begin : pe_driver
    bit acc;
    logic [DATA_W-1:0] d;
    pe_in.valid = 1'b0;
    pe_in.data  = '0;
    forever begin
      @(negedge clk);
      acc = pe_in.valid && pe_in.ready && rst_n;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pe_in.valid = 1'b0;
        pe_in.data  = '0;
      end else begin
        if (acc && pe_src_q.size() > 0) begin
          d = pe_src_q.pop_front();
          model_accept(d, 1'b1);
          pe_in.valid = 1'b0;
        end
        if (!pe_in.valid && pe_src_q.size() > 0 && (!rand_gaps || $urandom_range(0, 3) != 0)) begin
          pe_in.valid = 1'b1;
          pe_in.data  = pe_src_q[0];
        end
      end
    end
  end

  initial begin : sink_driver
    ring_out.ready = 1'b1;
    pe_out.ready   = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ring_out.ready = (ro_mode == 0) ? 1'b1 : (ro_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      pe_out.ready   = (po_mode == 0) ? 1'b1 : (po_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // ---------------- compare process ----------------
  task automatic take_ring_out(input logic [DATA_W-1:0] d);
    checks++;
    if (exp_ro_from_ring.size() > 0 && exp_ro_from_ring[0] == d) void'(exp_ro_from_ring.pop_front());
    else if (exp_ro_from_pe.size() > 0 && exp_ro_from_pe[0] == d) void'(exp_ro_from_pe.pop_front());
    else begin
      errors++;
      $display("FAIL ring_out_flit: got %02h, expected ring-src head %s or pe-src head %s",
               d, head_str(exp_ro_from_ring), head_str(exp_ro_from_pe));
    end
    ro_d.push_back(int'(d));
    ro_c.push_back(cyc + 1);
  endtask

  task automatic take_pe_out(input logic [DATA_W-1:0] d);
    checks++;
    if (exp_po_from_ring.size() > 0 && exp_po_from_ring[0] == d) void'(exp_po_from_ring.pop_front());
    else if (exp_po_from_pe.size() > 0 && exp_po_from_pe[0] == d) void'(exp_po_from_pe.pop_front());
    else begin
      errors++;
      $display("FAIL pe_out_flit: got %02h, expected ring-src head %s or pe-src head %s",
               d, head_str(exp_po_from_ring), head_str(exp_po_from_pe));
    end
    po_d.push_back(int'(d));
    po_c.push_back(cyc + 1);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      ro_hold = 1'b0;
      po_hold = 1'b0;
    end else begin
      if (ro_hold) begin
        chk("ring_out_stall_valid", 32'(ring_out.valid), 32'd1);
        chk("ring_out_stall_data", 32'(ring_out.data), 32'(ro_hold_d));
      end
      if (po_hold) begin
        chk("pe_out_stall_valid", 32'(pe_out.valid), 32'd1);
        chk("pe_out_stall_data", 32'(pe_out.data), 32'(po_hold_d));
      end
      if (ring_out.valid === 1'b1 && ring_out.ready === 1'b1) take_ring_out(ring_out.data);
      if (pe_out.valid === 1'b1 && pe_out.ready === 1'b1) take_pe_out(pe_out.data);
      ro_hold   = (ring_out.valid === 1'b1) && (ring_out.ready === 1'b0);
      ro_hold_d = ring_out.data;
      po_hold   = (pe_out.valid === 1'b1) && (pe_out.ready === 1'b0);
      po_hold_d = pe_out.data;
    end
  end

  // ---------------- sequencing helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("rst_ring_out_valid", 32'(ring_out.valid), 32'd0);
    chk("rst_ring_out_data", 32'(ring_out.data), 32'd0);
    chk("rst_pe_out_valid", 32'(pe_out.valid), 32'd0);
    chk("rst_pe_out_data", 32'(pe_out.data), 32'd0);
    chk("rst_ring_fifo_full", 32'(ring_fifo_full), 32'd0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ring_in_ready", 32'(ring_in.ready), 32'd1);
    chk("rst_pe_in_ready", 32'(pe_in.ready), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (ring_src_q.size() == 0 && pe_src_q.size() == 0 &&
          !ring_in.valid && !pe_in.valid &&
          exp_ro_from_ring.size() == 0 && exp_ro_from_pe.size() == 0 &&
          exp_po_from_ring.size() == 0 && exp_po_from_pe.size() == 0 &&
          ring_out.valid === 1'b0 && pe_out.valid === 1'b0) begin
        done = 1'b1;
      end
    end
    chk(name, 32'(done), 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int exp3[6];
    exp3 = '{'h20, 'h30, 'h21, 'h31, 'h22, 'h32};

    // Eject vs forward from the ring input.
    do_reset();
    ring_src_q.push_back(8'h15);
    ring_src_q.push_back(8'h25);
    wait_idle("t1_drain", 50);
    chk("t1_pe_count", po_d.size(), 1);
    chk("t1_pe_data", qat(po_d, 0), 'h15);
    chk("t1_ring_count", ro_d.size(), 1);
    chk("t1_ring_data", qat(ro_d, 0), 'h25);
    chk("t1_pe_latency", qat(po_c, 0) - qat(ring_acc_c, 0), 2);
    chk("t1_ring_after_pe", qat(ro_c, 0) - qat(po_c, 0), 1);

    // PE injection and local loopback.
    do_reset();
    pe_src_q.push_back(8'h3A);
    wait_idle("t2a_drain", 50);
    chk("t2_ring_data", qat(ro_d, 0), 'h3A);
    chk("t2_ring_latency", qat(ro_c, 0) - qat(pe_acc_c, 0), 2);
    pe_src_q.push_back(8'h1C);
    wait_idle("t2b_drain", 50);
    chk("t2_pe_count", po_d.size(), 1);
    chk("t2_pe_data", qat(po_d, 0), 'h1C);
    chk("t2_ring_count", ro_d.size(), 1);

    // Contention on ring_out: strict alternation at full rate.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ring_src_q.push_back(8'(8'h20 + i));
      pe_src_q.push_back(8'(8'h30 + i));
    end
    wait_idle("t3_drain", 60);
    chk("t3_count", ro_d.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("t3_order_%0d", i), qat(ro_d, i), exp3[i]);
    for (int i = 1; i < 6; i++) chk($sformatf("t3_rate_%0d", i), qat(ro_c, i) - qat(ro_c, i - 1), 1);

    // Back-pressure fills the ring FIFO, then drains in order.
    do_reset();
    ro_mode = 2;
    @(negedge clk);
    for (int i = 0; i < 8; i++) ring_src_q.push_back(8'(8'h20 + i));
    repeat (12) @(negedge clk);
    chk("t4_accepts", ring_acc_c.size(), 1 + FIFO_DEPTH);
    chk("t4_ring_in_ready", 32'(ring_in.ready), 32'd0);
    chk("t4_fifo_full", 32'(ring_fifo_full), 32'd1);
    chk("t4_out_valid", 32'(ring_out.valid), 32'd1);
    chk("t4_out_data", 32'(ring_out.data), 32'h20);
    ro_mode = 0;
    wait_idle("t4_drain", 100);
    chk("t4_count", ro_d.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("t4_order_%0d", i), qat(ro_d, i), 'h20 + i);

    // Eject and forward granted in the same cycle.
    do_reset();
    ring_src_q.push_back(8'h15);
    pe_src_q.push_back(8'h3A);
    wait_idle("t5_drain", 50);
    chk("t5_pe_data", qat(po_d, 0), 'h15);
    chk("t5_ring_data", qat(ro_d, 0), 'h3A);
    chk("t5_same_cycle", qat(po_c, 0) - qat(ro_c, 0), 0);
    chk("t5_latency", qat(ro_c, 0) - qat(pe_acc_c, 0), 2);

    // Reset in the middle of stalled traffic discards everything in flight.
    do_reset();
    ro_mode = 2;
    @(negedge clk);
    for (int i = 0; i < 4; i++) ring_src_q.push_back(8'(8'h20 + i));
    pe_src_q.push_back(8'h3B);
    repeat (4) @(negedge clk);
    chk("t6_pre_valid", 32'(ring_out.valid), 32'd1);
    ro_mode = 0;
    do_reset();
    ring_src_q.push_back(8'h25);
    wait_idle("t6_drain", 50);
    chk("t6_ring_count", ro_d.size(), 1);
    chk("t6_ring_data", qat(ro_d, 0), 'h25);
    chk("t6_latency", qat(ro_c, 0) - qat(ring_acc_c, 0), 2);
    chk("t6_pe_count", po_d.size(), 0);

    // Randomized traffic. Bit 7 tags the source so the scoreboard can tell the two streams apart.
    do_reset();
    rand_gaps = 1'b1;
    ro_mode = 1;
    po_mode = 1;
    repeat (800) begin
      @(negedge clk);
      if (ring_src_q.size() < 4 && $urandom_range(0, 2) != 0)
        ring_src_q.push_back({1'b0, 7'($urandom_range(0, 127))});
      if (pe_src_q.size() < 4 && $urandom_range(0, 2) != 0)
        pe_src_q.push_back({1'b1, 7'($urandom_range(0, 127))});
    end
    ro_mode = 0;
    po_mode = 0;
    wait_idle("rand_drain", 400);
    chk("rand_conservation", ro_d.size() + po_d.size(), ring_acc_c.size() + pe_acc_c.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected the sequence to complete");
    $fatal(1, "watchdog expired");
  end
endmodule
